// File: rtl/kbd_scan.sv
// rtl/kbd_scan.sv - 4x4 matrix keypad scanner with frame-based debounce
//
// Purpose:
//   Drives one keypad row low at a time, samples the four column lines
//   through a two-flop synchroniser, condenses each full 4-row scan into
//   a frame result (no key, exactly one key, or several keys), and
//   debounces those frame results into a key code, a one-cycle accept
//   strobe and a held-key level.
//
// Ports:
//   clk        in   1  scan clock, rising edge
//   rst        in   1  synchronous active-low reset
//   col_in     in   4  keypad columns, asynchronous, pulled up, 0 = closed
//   row_out    out  4  row drive, active-low, exactly one bit low
//   key_code   out  4  last accepted key, row*4+col
//   key_valid  out  1  one-cycle pulse when a press is accepted
//   key_down   out  1  high from acceptance until the release is debounced
//
// Parameters:
//   SCAN_DIV   clk cycles per row slot (4..255)
//   DEB_CNT    identical frames needed to accept a press or release (2..15)

module kbd_scan #(
  parameter int SCAN_DIV = 4,
  parameter int DEB_CNT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } state_t;

  localparam logic [7:0] SLOT_LAST = 8'(SCAN_DIV - 1);
  localparam logic [3:0] DEB_LAST  = 4'(DEB_CNT);

  // Column synchroniser
  logic [3:0] col_meta;
  logic [3:0] col_sync;

  // Row scan
  logic [7:0] slot_cnt;
  logic [1:0] row_idx;

  // Per-frame accumulators: closed-key count saturating at 2, first code
  logic [1:0] acc_cnt;
  logic [3:0] acc_code;

  // Debounce state
  state_t     state;
  logic [3:0] cand;
  logic [3:0] deb_cnt;
  logic [3:0] deb_next;

  // Combinational view of the current row sample merged into the frame
  logic [3:0] closed;
  logic [2:0] row_keys;
  logic [1:0] low_col;
  logic [2:0] key_sum;
  logic [1:0] frame_cnt;
  logic [3:0] frame_code;
  logic       sample_now;
  logic       eval_now;
  logic       frame_none;
  logic       frame_single;

  assign closed     = ~col_sync;
  assign sample_now = (slot_cnt == SLOT_LAST);
  // Last sample of row 3 closes the frame
  assign eval_now   = sample_now && (row_idx == 2'd3);
  assign deb_next   = deb_cnt + 4'd1;

  // Count closed columns on this row and find the lowest closed column.
  // Iterating from high to low leaves the lowest index in low_col.
  always_comb begin
    row_keys = 3'd0;
    low_col  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (closed[i]) begin
        low_col  = i[1:0];
        row_keys = row_keys + 3'd1;
      end
    end
  end

  // Merge this row into the running frame totals. Rows are scanned in
  // ascending order, so the first row that contributes any key supplies
  // the frame code (lowest row, then lowest column).
  always_comb begin
    key_sum = {1'b0, acc_cnt} + row_keys;
    if (key_sum >= 3'd2) begin
      frame_cnt = 2'd2;
    end else begin
      frame_cnt = key_sum[1:0];
    end
    if (acc_cnt == 2'd0) begin
      frame_code = {row_idx, low_col};
    end else begin
      frame_code = acc_code;
    end
  end

  assign frame_none   = (frame_cnt == 2'd0);
  assign frame_single = (frame_cnt == 2'd1);

  // Synchroniser, row scan and frame accumulation
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_meta <= 4'b1111;
      col_sync <= 4'b1111;
      slot_cnt <= 8'd0;
      row_idx  <= 2'd0;
      row_out  <= 4'b1110;
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
      if (sample_now) begin
        slot_cnt <= 8'd0;
        row_idx  <= row_idx + 2'd1;
        row_out  <= ~(4'b0001 << (row_idx + 2'd1));
        if (eval_now) begin
          acc_cnt  <= 2'd0;
          acc_code <= 4'd0;
        end else begin
          acc_cnt  <= frame_cnt;
          acc_code <= frame_code;
        end
      end else begin
        slot_cnt <= slot_cnt + 8'd1;
      end
    end
  end

  // Debounce FSM; only moves on frame evaluation. key_valid is cleared
  // every cycle so an accept can never stretch past one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cand      <= 4'd0;
      deb_cnt   <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (eval_now) begin
        case (state)
          IDLE: begin
            if (frame_single) begin
              state   <= PRESS_DEB;
              cand    <= frame_code;
              deb_cnt <= 4'd1;
            end
          end
          PRESS_DEB: begin
            if (frame_single && (frame_code == cand)) begin
              if (deb_next == DEB_LAST) begin
                state     <= HELD;
                key_code  <= cand;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                deb_cnt   <= 4'd0;
              end else begin
                deb_cnt <= deb_next;
              end
            end else if (frame_single) begin
              // A different single key restarts the count on that key
              cand    <= frame_code;
              deb_cnt <= 4'd1;
            end else begin
              state   <= IDLE;
              deb_cnt <= 4'd0;
            end
          end
          HELD: begin
            // Extra or changed keys are ignored until a full release
            if (frame_none) begin
              state   <= REL_DEB;
              deb_cnt <= 4'd1;
            end
          end
          REL_DEB: begin
            if (frame_none) begin
              if (deb_next == DEB_LAST) begin
                state    <= IDLE;
                key_down <= 1'b0;
                deb_cnt  <= 4'd0;
              end else begin
                deb_cnt <= deb_next;
              end
            end else begin
              state   <= HELD;
              deb_cnt <= 4'd0;
            end
          end
          default: begin
            state   <= IDLE;
            deb_cnt <= 4'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kbd_scan.sv
// tb/tb_kbd_scan.sv - directed self-checking bench for kbd_scan

module tb_kbd_scan;

  logic       clk;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [15:0] keys;

  int errors;
  int checks;
  int cyc;
  int pulses;
  int last_pulse;
  int dbl;
  int glitch;
  int down_seen;
  logic       prev_valid;
  logic [3:0] prev_code;
  logic [3:0] exp_row;

  kbd_scan #(.SCAN_DIV(4), .DEB_CNT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a closed key pulls its column low while its row is driven
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      if (!row_out[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4+c]) col_in[c] = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; cyc counts edges since reset release (0 while in reset)
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) cyc++;
    else cyc = 0;
    if (key_valid) begin
      pulses++;
      last_pulse = cyc;
      if (prev_valid) dbl++;
    end
    if (key_down) down_seen++;
    if ((key_code !== prev_code) && !key_valid) glitch++;
    prev_valid = key_valid;
    prev_code  = key_code;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) tick();
    rst = 1'b1;
    pulses     = 0;
    last_pulse = -1;
    dbl        = 0;
    glitch     = 0;
    down_seen  = 0;
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    keys       = 16'h0000;
    rst        = 1'b0;
    prev_valid = 1'b0;
    prev_code  = 4'd0;

    // 1: idle scan
    do_reset(3);
    check("rst_row_out", {28'd0, row_out}, 32'hE);
    check("rst_key_code", {28'd0, key_code}, 32'd0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_down", {31'd0, key_down}, 32'd0);
    for (int k = 0; k < 100; k++) begin
      tick();
      exp_row = ~(4'b0001 << ((cyc / 4) % 4));
      check("scan_row_out", {28'd0, row_out}, {28'd0, exp_row});
    end
    check("idle_pulses", pulses, 0);
    check("idle_down", down_seen, 0);

    // 2: key 6 closed from reset release
    keys = 16'h0000;
    keys[6] = 1'b1;
    do_reset(2);
    repeat (100) tick();
    check("k6_pulses", pulses, 1);
    check("k6_latency", last_pulse, 64);
    check("k6_code", {28'd0, key_code}, 32'd6);
    check("k6_down", {31'd0, key_down}, 32'd1);
    check("k6_no_double", dbl, 0);
    check("k6_code_glitch", glitch, 0);

    // 3: key 9 on alternate frames
    keys = 16'h0000;
    do_reset(2);
    for (int f = 0; f < 8; f++) begin
      keys = ((f % 2) == 0) ? 16'h0200 : 16'h0000;
      repeat (16) tick();
    end
    keys = 16'h0000;
    check("alt9_pulses", pulses, 0);
    check("alt9_code", {28'd0, key_code}, 32'd0);
    check("alt9_down", down_seen, 0);

    // 4: ghost pair 3+12, release, then 12 alone
    keys = 16'h1008;
    do_reset(2);
    repeat (128) tick();
    check("multi_pulses", pulses, 0);
    keys = 16'h0000;
    repeat (16) tick();
    keys = 16'h1000;
    repeat (64) tick();
    check("k12_pulses", pulses, 1);
    check("k12_latency", last_pulse, 208);
    check("k12_code", {28'd0, key_code}, 32'd12);
    check("k12_glitch", glitch, 0);

    // 5: hold 15, bounce on release
    keys = 16'h8000;
    do_reset(2);
    repeat (320) tick();
    check("k15_pulses", pulses, 1);
    check("k15_latency", last_pulse, 64);
    check("k15_code", {28'd0, key_code}, 32'd15);
    check("k15_down_held", {31'd0, key_down}, 32'd1);
    keys = 16'h0000;
    repeat (16) tick();
    keys = 16'h8000;
    repeat (16) tick();
    keys = 16'h0000;
    repeat (63) tick();
    check("k15_rel_cyc", cyc, 415);
    check("k15_down_before", {31'd0, key_down}, 32'd1);
    tick();
    check("k15_down_after", {31'd0, key_down}, 32'd0);
    check("k15_one_pulse", pulses, 1);
    check("k15_no_double", dbl, 0);

    // 6: reset during a debounce of key 5
    keys = 16'h0020;
    do_reset(2);
    repeat (32) tick();
    rst = 1'b0;
    tick();
    check("mid_rst_row_out", {28'd0, row_out}, 32'hE);
    check("mid_rst_code", {28'd0, key_code}, 32'd0);
    check("mid_rst_valid", {31'd0, key_valid}, 32'd0);
    check("mid_rst_down", {31'd0, key_down}, 32'd0);
    check("mid_rst_prepulse", pulses, 0);
    rst = 1'b1;
    repeat (100) tick();
    check("k5_pulses", pulses, 1);
    check("k5_latency", last_pulse, 64);
    check("k5_code", {28'd0, key_code}, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
